alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 177 +++++++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with a valid/ready handshake on
// both sides.
//
// Stage S1 captures the operands and opcode. Stage S2 evaluates the ALU
// function from S1 and registers the result, the flags and a valid bit.
// Fixed-point multiply and optional saturation are selected by parameters.
//
// Parameters:
//   N    - operand/result width (4..32)
//   FRAC - fractional bits of the fixed-point multiply (0..N-1)
//   SAT  - 1 = saturate ADD/MUL on overflow, 0 = wrap
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   nReset    - asynchronous active-low reset
//   in_valid  - an operation is presented on a, b, func
//   in_ready  - the block accepts the presented operation this cycle
//   a, b      - signed operands
//   func      - opcode: PASS_A, PASS_B, ADD, MUL, AND, OR, XOR, NOT_A
//   out_valid - result and flags are valid
//   out_ready - downstream accepts the result
//   result    - signed result
//   flags     - {V overflow, Nf negative, Z zero}

module alu_pipe #(
  parameter int N    = 8,
  parameter int FRAC = N - 1,
  parameter bit SAT  = 1'b0
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [2:0]          func,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] result,
  output logic [2:0]          flags
);

  typedef enum logic [2:0] {
    OP_PASS_A = 3'd0,
    OP_PASS_B = 3'd1,
    OP_ADD    = 3'd2,
    OP_MUL    = 3'd3,
    OP_AND    = 3'd4,
    OP_OR     = 3'd5,
    OP_XOR    = 3'd6,
    OP_NOT_A  = 3'd7
  } func_e;

  localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic                s1_valid_q, s1_valid_d;
  logic signed [N-1:0] s1_a_q, s1_a_d;
  logic signed [N-1:0] s1_b_q, s1_b_d;
  func_e               s1_func_q, s1_func_d;

  logic                s2_valid_q, s2_valid_d;
  logic [N-1:0]        result_q, result_d;
  logic [2:0]          flags_q, flags_d;

  logic                s1_adv, s2_adv;

  logic [N:0]            sum_w;
  logic signed [2*N-1:0] prod_w;
  logic signed [2*N-1:0] q_w;
  logic [N-1:0]          alu_raw;
  logic                  alu_v;
  logic                  true_neg;
  logic [N-1:0]          res_final;

  // A stage moves forward when it is empty or its successor is moving, so a
  // full pipeline can accept and drain in the same cycle without a bubble.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  // S1 capture: payload only changes when a new operation is actually taken.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_func_d  = s1_func_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_func_d = func_e'(func);
      end
    end
  end

  // ALU evaluation from S1. The ADD sum is kept at N+1 bits so the true sign
  // is known for overflow and saturation. The multiply sign-extends both
  // operands to 2N bits; the low 2N bits of that product equal the signed
  // product, and the arithmetic shift truncates toward -inf.
  always_comb begin
    sum_w    = {s1_a_q[N-1], s1_a_q} + {s1_b_q[N-1], s1_b_q};
    prod_w   = {{N{s1_a_q[N-1]}}, s1_a_q} * {{N{s1_b_q[N-1]}}, s1_b_q};
    q_w      = prod_w >>> FRAC;
    alu_raw  = s1_a_q;
    alu_v    = 1'b0;
    true_neg = 1'b0;
    case (s1_func_q)
      OP_PASS_A: alu_raw = s1_a_q;
      OP_PASS_B: alu_raw = s1_b_q;
      OP_ADD: begin
        alu_raw  = sum_w[N-1:0];
        alu_v    = sum_w[N] ^ sum_w[N-1];
        true_neg = sum_w[N];
      end
      OP_MUL: begin
        alu_raw  = q_w[N-1:0];
        // Q fits in N bits only if everything from bit N-1 upward is a copy
        // of the sign.
        alu_v    = !((&q_w[2*N-1:N-1]) || !(|q_w[2*N-1:N-1]));
        true_neg = q_w[2*N-1];
      end
      OP_AND:   alu_raw = s1_a_q & s1_b_q;
      OP_OR:    alu_raw = s1_a_q | s1_b_q;
      OP_XOR:   alu_raw = s1_a_q ^ s1_b_q;
      OP_NOT_A: alu_raw = ~s1_a_q;
      default:  alu_raw = s1_a_q;
    endcase
    res_final = (SAT && alu_v) ? (true_neg ? MIN_VAL : MAX_VAL) : alu_raw;
  end

  // S2 capture: Nf and Z come from the post-saturation value; V is reported
  // regardless of the saturation mode.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_final;
        flags_d  = {alu_v, res_final[N-1], (res_final == '0)};
      end
    end
  end

  // State registers; reset empties both stages and zeroes the visible outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_func_q  <= OP_PASS_A;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_func_q  <= s1_func_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    result    = result_q;
    flags     = flags_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe at N=8, FRAC=7.
// One instance wraps on overflow and one saturates; both see identical
// inputs so their handshakes match, and each table entry carries the
// hand-computed result and flags for both modes. Hand-written sequences
// cover backpressure, toggling out_ready and a mid-flight reset.

module tb_alu_pipe;

  localparam logic [2:0] F_PASS_A = 3'd0;
  localparam logic [2:0] F_PASS_B = 3'd1;
  localparam logic [2:0] F_ADD    = 3'd2;
  localparam logic [2:0] F_MUL    = 3'd3;
  localparam logic [2:0] F_AND    = 3'd4;
  localparam logic [2:0] F_OR     = 3'd5;
  localparam logic [2:0] F_XOR    = 3'd6;
  localparam logic [2:0] F_NOT_A  = 3'd7;

  logic       clk;
  logic       nReset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] func;

  logic       in_ready_w, out_valid_w;
  logic [7:0] result_w;
  logic [2:0] flags_w;
  logic       in_ready_s, out_valid_s;
  logic [7:0] result_s;
  logic [2:0] flags_s;

  typedef struct {
    string      name;
    logic [2:0] func;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res_w;
    logic [2:0] flg_w;
    logic [7:0] res_s;
    logic [2:0] flg_s;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] op_func[$];
  logic [7:0] op_a[$];
  logic [7:0] op_b[$];
  logic [7:0] op_exp[$];
  int         sent;
  int         received;
  int         checks;
  int         fails;

  alu_pipe #(.N(8), .FRAC(7), .SAT(1'b0)) dut_wrap (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .func(func), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .flags(flags_w)
  );

  alu_pipe #(.N(8), .FRAC(7), .SAT(1'b1)) dut_sat (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .func(func), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .flags(flags_s)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] f,
                               input logic [7:0] av, input logic [7:0] bv);
    in_valid = valid;
    func     = f;
    a        = av;
    b        = bv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string name, input logic [2:0] f,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] rw, input logic [2:0] fw,
                        input logic [7:0] rs, input logic [2:0] fs);
    vec_t v;
    v.name  = name;
    v.func  = f;
    v.a     = av;
    v.b     = bv;
    v.res_w = rw;
    v.flg_w = fw;
    v.res_s = rs;
    v.flg_s = fs;
    vecs.push_back(v);
  endtask

  task automatic addOp(input logic [2:0] f, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] ev);
    op_func.push_back(f);
    op_a.push_back(av);
    op_b.push_back(bv);
    op_exp.push_back(ev);
  endtask

  task automatic clearOps();
    op_func.delete();
    op_a.delete();
    op_b.delete();
    op_exp.delete();
    sent     = 0;
    received = 0;
  endtask

  // Feeds the queued operations (continuing from the current sent/received
  // counts) and scoreboards every output transfer in order. Afterwards the
  // pipeline must stay empty: no duplicated results.
  task automatic streamOps(input bit toggle_ready, input int budget,
                           input string tag);
    int cyc;
    int gaps;
    int extra;
    bit started;
    bit in_acc;
    bit out_acc;
    cyc     = 0;
    gaps    = 0;
    extra   = 0;
    started = 1'b0;
    while (received < op_exp.size() && cyc < budget) begin
      out_ready = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
      if (sent < op_exp.size())
        applyStimulus(1'b1, op_func[sent], op_a[sent], op_b[sent]);
      else
        applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
      #1;
      in_acc  = in_valid && in_ready_w;
      out_acc = out_valid_w && out_ready;
      if (out_acc) begin
        checkOutput($sformatf("%s result[%0d]", tag, received), result_w, op_exp[received]);
        received++;
        started = 1'b1;
      end else if (started && !toggle_ready) begin
        gaps++;
      end
      @(posedge clk);
      #1;
      if (in_acc) sent++;
      cyc++;
    end
    checkOutput({tag, " output count"}, received, op_exp.size());
    if (!toggle_ready) checkOutput({tag, " gaps"}, gaps, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    out_ready = 1'b1;
    repeat (4) begin
      if (out_valid_w) extra++;
      tick();
    end
    checkOutput({tag, " extra outputs"}, extra, 0);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    fails  = 0;
    sent   = 0;
    received = 0;

    //      name           func      a      b      res_w  flg_w   res_s  flg_s
    addVec("add_ovf",      F_ADD,    8'd100, 8'd50, 8'h96, 3'b110, 8'h7F, 3'b100);
    addVec("mul_half",     F_MUL,    8'h40, 8'h40, 8'h20, 3'b000, 8'h20, 3'b000);
    addVec("mul_minmin",   F_MUL,    8'h80, 8'h80, 8'h80, 3'b110, 8'h7F, 3'b100);
    addVec("xor_zero",     F_XOR,    8'h5A, 8'h5A, 8'h00, 3'b001, 8'h00, 3'b001);
    addVec("pass_a",       F_PASS_A, 8'h85, 8'h12, 8'h85, 3'b010, 8'h85, 3'b010);
    addVec("pass_b",       F_PASS_B, 8'h85, 8'h12, 8'h12, 3'b000, 8'h12, 3'b000);
    addVec("and",          F_AND,    8'hF0, 8'h3C, 8'h30, 3'b000, 8'h30, 3'b000);
    addVec("or",           F_OR,     8'hF0, 8'h0C, 8'hFC, 3'b010, 8'hFC, 3'b010);
    addVec("not_a",        F_NOT_A,  8'hFF, 8'h00, 8'h00, 3'b001, 8'h00, 3'b001);
    addVec("add_neg_ovf",  F_ADD,    8'h80, 8'hFF, 8'h7F, 3'b100, 8'h80, 3'b110);
    addVec("add_to_zero",  F_ADD,    8'h7F, 8'h81, 8'h00, 3'b001, 8'h00, 3'b001);
    addVec("mul_neg",      F_MUL,    8'hC0, 8'h40, 8'hE0, 3'b010, 8'hE0, 3'b010);
    addVec("mul_floor",    F_MUL,    8'hFF, 8'h01, 8'hFF, 3'b010, 8'hFF, 3'b010);
    addVec("mul_maxmax",   F_MUL,    8'h7F, 8'h7F, 8'h7E, 3'b000, 8'h7E, 3'b000);
    addVec("add_pos_edge", F_ADD,    8'h7F, 8'h01, 8'h80, 3'b110, 8'h7F, 3'b100);

    // Reset state.
    nReset    = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    #2;
    checkOutput("reset out_valid", out_valid_w, 1'b0);
    checkOutput("reset result", result_w, 8'h00);
    checkOutput("reset flags", flags_w, 3'b000);
    checkOutput("reset in_ready", in_ready_w, 1'b1);
    checkOutput("reset out_valid sat", out_valid_s, 1'b0);
    #1;
    nReset = 1'b1;

    // Single operations: out_valid must be low one edge after acceptance,
    // high after the second edge, and low again once drained.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(1'b1, v.func, v.a, v.b);
      out_ready = 1'b1;
      #1;
      checkOutput({v.name, " in_ready"}, in_ready_w, 1'b1);
      tick();
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
      checkOutput({v.name, " out_valid early"}, out_valid_w, 1'b0);
      tick();
      checkOutput({v.name, " out_valid"}, out_valid_w, 1'b1);
      checkOutput({v.name, " result wrap"}, result_w, v.res_w);
      checkOutput({v.name, " flags wrap"}, flags_w, v.flg_w);
      checkOutput({v.name, " result sat"}, result_s, v.res_s);
      checkOutput({v.name, " flags sat"}, flags_s, v.flg_s);
      tick();
      checkOutput({v.name, " out_valid drained"}, out_valid_w, 1'b0);
    end

    // Backpressure: with out_ready low only two operations fit, then the
    // input stalls and the held output stays put.
    clearOps();
    addOp(F_ADD, 8'h01, 8'h02, 8'h03);
    addOp(F_ADD, 8'h03, 8'h04, 8'h07);
    addOp(F_XOR, 8'h0F, 8'hF0, 8'hFF);
    addOp(F_OR,  8'h10, 8'h02, 8'h12);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bit acc;
      applyStimulus(1'b1, op_func[sent], op_a[sent], op_b[sent]);
      #1;
      acc = in_ready_w;
      if (c >= 2) begin
        checkOutput($sformatf("stall result c%0d", c), result_w, 8'h03);
        checkOutput($sformatf("stall flags c%0d", c), flags_w, 3'b000);
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    checkOutput("stall accepted", sent, 2);
    #1;
    checkOutput("stall in_ready", in_ready_w, 1'b0);
    checkOutput("stall out_valid", out_valid_w, 1'b1);
    streamOps(1'b0, 20, "backpressure");

    // Streaming with out_ready toggling every cycle.
    clearOps();
    addOp(F_ADD,    8'd10,  8'd20,  8'h1E);
    addOp(F_PASS_B, 8'h00,  8'h55,  8'h55);
    addOp(F_AND,    8'h0F,  8'h3C,  8'h0C);
    addOp(F_NOT_A,  8'h0F,  8'h00,  8'hF0);
    addOp(F_OR,     8'h40,  8'h02,  8'h42);
    addOp(F_XOR,    8'h11,  8'h22,  8'h33);
    streamOps(1'b1, 40, "toggle");

    // Reset with both stages full discards everything in flight.
    clearOps();
    out_ready = 1'b0;
    applyStimulus(1'b1, F_MUL, 8'h40, 8'h40);
    tick();
    applyStimulus(1'b1, F_ADD, 8'h05, 8'h05);
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("prereset out_valid", out_valid_w, 1'b1);
    checkOutput("prereset in_ready", in_ready_w, 1'b0);
    nReset = 1'b0;
    #1;
    checkOutput("midreset out_valid", out_valid_w, 1'b0);
    checkOutput("midreset out_valid sat", out_valid_s, 1'b0);
    checkOutput("midreset result", result_w, 8'h00);
    checkOutput("midreset flags", flags_w, 3'b000);
    checkOutput("midreset in_ready", in_ready_w, 1'b1);
    #2;
    nReset = 1'b1;
    addOp(F_PASS_A, 8'h6B, 8'h00, 8'h6B);
    streamOps(1'b0, 10, "postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
